// File: rtl/cnn_pkg.sv
// Shared definitions for the 4x4 CNN array and its result-side reader.
package cnn_pkg;

    localparam int unsigned N_CELLS     = 16;
    localparam int unsigned GRID_DIM    = 4;
    localparam int unsigned DATA_W_DFLT = 9;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StStream
    } reader_state_t;

    // Extract cell k (raster order) from the packed array output bus.
    function automatic logic signed [DATA_W_DFLT-1:0] get_cell(
        input logic [N_CELLS*DATA_W_DFLT-1:0] y,
        input int unsigned                    k
    );
        return y[k*DATA_W_DFLT +: DATA_W_DFLT];
    endfunction

endpackage

// File: rtl/cnn_frame_reader_if.sv
// Valid/ready result stream carrying one cell value per beat.
interface cnn_frame_reader_if #(
    parameter int unsigned DATA_W = 9
);
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic [3:0]               out_idx;
    logic                     out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/cnn_frame_reader.sv
// Result-side reader for the 4x4 CNN array: snapshots the array once per sweep, decides when the
// frame has settled (sweep limit, or convergence when CNN_READER_CONV_EN is defined), then streams
// the 16 snapshot cells in raster order.
module cnn_frame_reader
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DFLT,
    parameter int unsigned MAX_SWEEPS  = 8,
    parameter int unsigned SWEEP_CNT_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         sweep_done,
    input  logic [N_CELLS*DATA_W-1:0]    y_in,
    cnn_frame_reader_if.master           ob,
    output logic                         busy,
    output logic                         converged,
    output logic [SWEEP_CNT_W-1:0]       sweeps_used
);

    localparam logic [SWEEP_CNT_W-1:0] MaxCnt  = SWEEP_CNT_W'(MAX_SWEEPS);
    localparam logic [3:0]             LastIdx = 4'd15;

    reader_state_t            state;
    logic signed [DATA_W-1:0] cur [N_CELLS];
    logic [SWEEP_CNT_W-1:0]   sweeps_next;
    logic                     limit_hit;
    logic                     conv_hit;

    // Saturating sweep count and limit detection for the capture in progress.
    always_comb begin
        sweeps_next = (sweeps_used == MaxCnt) ? sweeps_used : sweeps_used + 1'b1;
        limit_hit   = (sweeps_next == MaxCnt);
    end

`ifdef CNN_READER_CONV_EN
    logic signed [DATA_W-1:0] prev [N_CELLS];
    logic                     prev_valid;
    logic                     same;

    // Incoming sweep is bit-exact equal to the held snapshot on every cell.
    always_comb begin
        same = 1'b1;
        for (int k = 0; k < N_CELLS; k++) begin
            if (get_cell(y_in, k) != cur[k]) same = 1'b0;
        end
    end

    assign conv_hit = prev_valid && same;

    // Previous snapshot and convergence flag, cleared when a new frame is armed.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            converged  <= 1'b0;
            for (int k = 0; k < N_CELLS; k++) prev[k] <= '0;
        end else if (state == StIdle && start) begin
            prev_valid <= 1'b0;
            converged  <= 1'b0;
        end else if (state == StSettle && sweep_done) begin
            prev       <= cur;
            prev_valid <= 1'b1;
            if (conv_hit) converged <= 1'b1;
        end
    end
`else
    assign conv_hit  = 1'b0;
    assign converged = 1'b0;
`endif

    // Frame FSM with registered stream outputs; the snapshot is frozen outside SETTLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            busy         <= 1'b0;
            sweeps_used  <= '0;
            ob.out_valid <= 1'b0;
            ob.out_data  <= '0;
            ob.out_idx   <= '0;
            ob.out_last  <= 1'b0;
            for (int k = 0; k < N_CELLS; k++) cur[k] <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state       <= StSettle;
                        busy        <= 1'b1;
                        sweeps_used <= '0;
                    end
                end
                StSettle: begin
                    if (sweep_done) begin
                        for (int k = 0; k < N_CELLS; k++) cur[k] <= get_cell(y_in, k);
                        sweeps_used <= sweeps_next;
                        if (conv_hit || limit_hit) begin
                            state        <= StStream;
                            ob.out_valid <= 1'b1;
                            ob.out_idx   <= '0;
                            ob.out_last  <= 1'b0;
                            // Beat 0 comes from the value being captured, not from y_in later.
                            ob.out_data  <= get_cell(y_in, 0);
                        end
                    end
                end
                StStream: begin
                    if (ob.out_valid && ob.out_ready) begin
                        if (ob.out_idx == LastIdx) begin
                            state        <= StIdle;
                            busy         <= 1'b0;
                            ob.out_valid <= 1'b0;
                            ob.out_last  <= 1'b0;
                            ob.out_idx   <= '0;
                        end else begin
                            ob.out_idx  <= ob.out_idx + 4'd1;
                            ob.out_data <= cur[ob.out_idx + 4'd1];
                            ob.out_last <= (ob.out_idx == LastIdx - 4'd1);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_frame_reader.sv
// Self-checking bench for cnn_frame_reader; expectations follow CNN_READER_CONV_EN when defined.
module tb_cnn_frame_reader;
    import cnn_pkg::*;

    localparam int MAX_SWEEPS = 8;
`ifdef CNN_READER_CONV_EN
    localparam bit CONV_EN = 1'b1;
`else
    localparam bit CONV_EN = 1'b0;
`endif

    typedef logic signed [8:0] frame_t [16];

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sweep_done;
    logic [143:0] y_in;
    logic         busy;
    logic         converged;
    logic [3:0]   sweeps_used;

    cnn_frame_reader_if #(.DATA_W(9)) ob ();

    cnn_frame_reader #(
        .DATA_W      (9),
        .MAX_SWEEPS  (MAX_SWEEPS),
        .SWEEP_CNT_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sweep_done  (sweep_done),
        .y_in        (y_in),
        .ob          (ob.master),
        .busy        (busy),
        .converged   (converged),
        .sweeps_used (sweeps_used)
    );

    always #5 clk = ~clk;

    int     n_cmp  = 0;
    int     n_fail = 0;
    frame_t hist[$];
    frame_t exp_snap;
    frame_t v;
    bit     done;
    int     saved_sweeps;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_y(input frame_t f);
        for (int k = 0; k < 16; k++) y_in[k*9 +: 9] = f[k];
    endtask

    task automatic rand_frame(output frame_t f, input int cell0);
        for (int k = 0; k < 16; k++) f[k] = 9'($urandom);
        f[0] = 9'(cell0);
    endtask

    task automatic start_frame();
        hist.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_sweeps", sweeps_used, 0);
        check("start_conv", converged, 0);
    endtask

    // Reference model: frame settles on an exact repeat (if enabled) or at the sweep limit.
    task automatic send_sweep(input frame_t f, output bit fin);
        int  n;
        bit  conv;
        hist.push_back(f);
        n    = hist.size();
        conv = 1'b0;
        if (CONV_EN && n >= 2) begin
            conv = 1'b1;
            for (int k = 0; k < 16; k++) if (hist[n-1][k] != hist[n-2][k]) conv = 1'b0;
        end
        fin = conv || (n == MAX_SWEEPS);
        drive_y(f);
        sweep_done = 1'b1;
        step();
        sweep_done = 1'b0;
        check("sweeps_used", sweeps_used, n);
        check("converged", converged, fin && conv);
        check("valid_after_sweep", ob.out_valid, fin);
        if (fin) exp_snap = f;
    endtask

    task automatic stream_frame(input int stall_at, input int stall_len, input int stop_at);
        int beat    = 0;
        int stalled = 0;
        int guard   = 0;
        while (beat < stop_at && guard < 64) begin
            check("beat_valid", ob.out_valid, 1);
            check("beat_idx", ob.out_idx, beat);
            check("beat_data", ob.out_data, exp_snap[beat]);
            check("beat_last", ob.out_last, beat == 15);
            if (beat == stall_at && stalled < stall_len) begin
                ob.out_ready = 1'b0;
                stalled++;
            end else begin
                ob.out_ready = 1'b1;
            end
            step();
            if (ob.out_ready) beat++;
            guard++;
        end
        check("beats_taken", beat, stop_at);
        ob.out_ready = 1'b0;
        if (stop_at == 16) begin
            check("end_valid", ob.out_valid, 0);
            check("end_busy", busy, 0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        sweep_done   = 1'b0;
        y_in         = '0;
        ob.out_ready = 1'b0;

        // Reset, then a sweep_done in IDLE must change nothing.
        repeat (3) step();
        check("rst_valid", ob.out_valid, 0);
        check("rst_data", ob.out_data, 0);
        check("rst_idx", ob.out_idx, 0);
        check("rst_last", ob.out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_conv", converged, 0);
        check("rst_sweeps", sweeps_used, 0);
        rst = 1'b0;
        step();
        rand_frame(v, 5);
        drive_y(v);
        sweep_done = 1'b1;
        step();
        sweep_done = 1'b0;
        check("idle_sweep_busy", busy, 0);
        check("idle_sweep_valid", ob.out_valid, 0);
        check("idle_sweep_cnt", sweeps_used, 0);

        // Convergence: two identical sweeps with cell k = k-8.
        start_frame();
        for (int k = 0; k < 16; k++) v[k] = 9'(k - 8);
        send_sweep(v, done);
        if (!done) send_sweep(v, done);
        for (int i = 3; i <= MAX_SWEEPS && !done; i++) begin
            rand_frame(v, 100 + i);
            send_sweep(v, done);
        end
        check("conv_flag", converged, CONV_EN);
        check("conv_sweeps", sweeps_used, CONV_EN ? 2 : MAX_SWEEPS);
        stream_frame(-1, 0, 16);

        // Sweep limit, with 5 cycles of backpressure at idx 3.
        start_frame();
        done = 1'b0;
        for (int i = 1; i <= MAX_SWEEPS && !done; i++) begin
            rand_frame(v, i);
            send_sweep(v, done);
        end
        check("limit_conv", converged, 0);
        check("limit_sweeps", sweeps_used, MAX_SWEEPS);
        check("limit_beat0", ob.out_data, MAX_SWEEPS);
        stream_frame(3, 5, 16);

        // start and sweep_done during STREAM are ignored; the snapshot stays frozen.
        start_frame();
        done = 1'b0;
        for (int i = 1; i <= MAX_SWEEPS && !done; i++) begin
            rand_frame(v, 20 + i);
            send_sweep(v, done);
        end
        saved_sweeps = hist.size();
        rand_frame(v, 200);
        drive_y(v);
        start      = 1'b1;
        sweep_done = 1'b1;
        step();
        start      = 1'b0;
        sweep_done = 1'b0;
        check("ign_busy", busy, 1);
        check("ign_sweeps", sweeps_used, saved_sweeps);
        check("ign_idx", ob.out_idx, 0);
        stream_frame(-1, 0, 16);

        // Mid-frame reset at idx 7, then a fresh frame streams from idx 0.
        start_frame();
        done = 1'b0;
        for (int i = 1; i <= MAX_SWEEPS && !done; i++) begin
            rand_frame(v, 40 + i);
            send_sweep(v, done);
        end
        stream_frame(-1, 0, 7);
        check("pre_rst_idx", ob.out_idx, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", ob.out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_idx", ob.out_idx, 0);
        check("mid_rst_sweeps", sweeps_used, 0);
        start_frame();
        done = 1'b0;
        for (int i = 1; i <= MAX_SWEEPS && !done; i++) begin
            rand_frame(v, 60 + i);
            send_sweep(v, done);
        end
        stream_frame(-1, 0, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
